sid_voice_mixer: RTL and testbench

Parametrised, time-multiplexed voice mixer and master-volume stage for SID-style synthesis cores. It accepts N amplified voices (envelope × waveform, signed) and routes each voice to the filter input or the bypass path. It sums the bypass path with the selected filter outputs and a mixer DC offset, clips the result, and applies the 4-bit master volume. With NUM_VOICES=3 its register semantics match the classic 0x17/0x18 filter-routing and mode/volume registers, so it can replace the fixed 3-voice mixer and also serve multi-SID and extended-voice builds.

---
 rtl/sid_voice_mixer_if.sv | 32 +++
 rtl/sid_voice_mixer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sid_voice_mixer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sid_voice_mixer_if.sv
// Bus interface for sid_voice_mixer: the sample strobe, the register write
// port, the voice and filter sample inputs, and the mix results.
// The master modport drives the inputs and the slave modport is the mixer.
interface sid_voice_mixer_if #(
   parameter int NUM_VOICES = 3,
   parameter int SAMPLE_W   = 16
);
   logic                               clkEn;
   logic                               iWE;
   logic        [4:0]                  iAddr;
   logic        [7:0]                  iDataW;
   logic        [NUM_VOICES*SAMPLE_W-1:0] iVoices;
   logic signed [SAMPLE_W-1:0]         iFiltLP;
   logic signed [SAMPLE_W-1:0]         iFiltBP;
   logic signed [SAMPLE_W-1:0]         iFiltHP;
   logic signed [SAMPLE_W-1:0]         oPreFilter;
   logic signed [SAMPLE_W-1:0]         oBypass;
   logic signed [SAMPLE_W-1:0]         oOut;
   logic                               oValid;
   logic                               oBusy;
   logic                               oOverrun;

   modport master (
      output clkEn, iWE, iAddr, iDataW, iVoices, iFiltLP, iFiltBP, iFiltHP,
      input  oPreFilter, oBypass, oOut, oValid, oBusy, oOverrun
   );

   modport slave (
      input  clkEn, iWE, iAddr, iDataW, iVoices, iFiltLP, iFiltBP, iFiltHP,
      output oPreFilter, oBypass, oOut, oValid, oBusy, oOverrun
   );
endinterface

// File: rtl/sid_voice_mixer.sv
// Time-multiplexed SID voice mixer and master-volume stage.
// Each clkEn snapshots the voices and registers, accumulates one voice per
// cycle into the filter-input or bypass sum, adds the selected filter
// outputs (and the mixer DC offset), clips, and scales by the 4-bit volume.
// Optional feature: define SID_MIXER_DC_EN to add DC_OFFSET after the filter;
// without it the DC term is zero.
module sid_voice_mixer #(
   parameter int NUM_VOICES     = 3,
   parameter int SAMPLE_W       = 16,
   parameter int HEADROOM_SHIFT = 3,
   parameter int BASE_ADDR      = 'h17,
   parameter int DC_OFFSET      = -3746
) (
   input logic              clk,
   input logic              iRstN,
   sid_voice_mixer_if.slave bus
);

   localparam int R_BYTES = (NUM_VOICES + 7) / 8;
   localparam int IDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int ACC_W   = SAMPLE_W + $clog2(NUM_VOICES) + 1;
   localparam int POST_W  = SAMPLE_W + 3;
   localparam int WIDE_W  = (ACC_W > POST_W) ? ACC_W : POST_W;
   localparam int VOICES_W = NUM_VOICES * SAMPLE_W;

   localparam logic [4:0] CTRL_ADDR = 5'(BASE_ADDR + R_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   localparam logic signed [WIDE_W-1:0] SAT_MAX =
      WIDE_W'((longint'(1) << (SAMPLE_W - 1)) - 1);
   localparam logic signed [WIDE_W-1:0] SAT_MIN =
      WIDE_W'(-(longint'(1) << (SAMPLE_W - 1)));

`ifdef SID_MIXER_DC_EN
   localparam logic signed [POST_W-1:0] DC_TERM = POST_W'(DC_OFFSET);
`else
   // DC_OFFSET is multiplied out so the parameter stays referenced.
   localparam logic signed [POST_W-1:0] DC_TERM = POST_W'(DC_OFFSET * 0);
`endif

   typedef enum logic [1:0] {IDLE, ACC, SUM, VOL} state_t;

   // Clamp a wide signed value into the SAMPLE_W signed range.
   function automatic logic signed [SAMPLE_W-1:0] sat(
      input logic signed [WIDE_W-1:0] x
   );
      if (x > SAT_MAX) begin
         return SAMPLE_W'(SAT_MAX);
      end else if (x < SAT_MIN) begin
         return SAMPLE_W'(SAT_MIN);
      end else begin
         return SAMPLE_W'(x);
      end
   endfunction

   // Programmable registers
   logic [NUM_VOICES-1:0] route_q;
   logic [2:0]            mode_q;
   logic                  last_off_q;
   logic [3:0]            vol_q;

   // Per-mix snapshot and datapath state
   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [VOICES_W-1:0]        snap_voices_q, snap_voices_d;
   logic [NUM_VOICES-1:0]      snap_route_q, snap_route_d;
   logic [2:0]                 snap_mode_q, snap_mode_d;
   logic                       snap_last_off_q, snap_last_off_d;
   logic [3:0]                 snap_vol_q, snap_vol_d;
   logic signed [ACC_W-1:0]    pre_acc_q, pre_acc_d;
   logic signed [ACC_W-1:0]    byp_acc_q, byp_acc_d;
   logic signed [SAMPLE_W-1:0] pre_sat_q, pre_sat_d;
   logic signed [SAMPLE_W-1:0] byp_sat_q, byp_sat_d;
   logic signed [SAMPLE_W-1:0] clip_q, clip_d;
   logic signed [SAMPLE_W-1:0] pre_o_q, pre_o_d;
   logic signed [SAMPLE_W-1:0] byp_o_q, byp_o_d;
   logic signed [SAMPLE_W-1:0] out_q, out_d;
   logic                       valid_q, valid_d;
   logic                       overrun_q, overrun_d;

   // Combinational helpers
   logic signed [SAMPLE_W-1:0]   voice_sel;
   logic signed [SAMPLE_W-1:0]   voice_shr;
   logic signed [ACC_W-1:0]      voice_ext;
   logic                         route_sel;
   logic signed [SAMPLE_W-1:0]   byp_sat_now;
   logic signed [POST_W-1:0]     lp_term, bp_term, hp_term, post;
   logic signed [SAMPLE_W+3:0]   vol_prod;

   // Register file writes; routing bits for nonexistent voices are not stored.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge iRstN) begin
      if (!iRstN) begin
         route_q    <= '0;
         mode_q     <= '0;
         last_off_q <= 1'b0;
         vol_q      <= 4'hF;
      end else if (bus.iWE) begin
         for (int j = 0; j < NUM_VOICES; j++) begin
            if (bus.iAddr == 5'(BASE_ADDR + j / 8)) begin
               route_q[j] <= bus.iDataW[j % 8];
            end
         end
         if (bus.iAddr == CTRL_ADDR) begin
            last_off_q <= bus.iDataW[7];
            mode_q     <= bus.iDataW[6:4];
            vol_q      <= bus.iDataW[3:0];
         end
      end
   end

   // Select the current voice sample and its routing bit from the snapshot.
   always_comb begin
      voice_sel = '0;
      route_sel = 1'b0;
      for (int k = 0; k < NUM_VOICES; k++) begin
         if (idx_q == IDX_W'(k)) begin
            voice_sel = snap_voices_q[k*SAMPLE_W +: SAMPLE_W];
            route_sel = snap_route_q[k];
         end
      end
   end

   assign voice_shr = voice_sel >>> HEADROOM_SHIFT;
   assign voice_ext = ACC_W'(voice_shr);

   // Post-filter sum uses the clipped bypass so POST_W cannot overflow for
   // any voice count; the filter taps are sampled while in SUM.
   assign byp_sat_now = sat(WIDE_W'(byp_acc_q));
   assign lp_term     = snap_mode_q[0] ? POST_W'(bus.iFiltLP) : '0;
   assign bp_term     = snap_mode_q[1] ? POST_W'(bus.iFiltBP) : '0;
   assign hp_term     = snap_mode_q[2] ? POST_W'(bus.iFiltHP) : '0;
   assign post        = POST_W'(byp_sat_now) + DC_TERM + lp_term + bp_term + hp_term;

   // Volume is zero-extended so the product stays a signed multiply.
   assign vol_prod = (SAMPLE_W + 4)'(clip_q) * (SAMPLE_W + 4)'($signed({1'b0, snap_vol_q}));

   // Next-state and datapath decode for the IDLE/ACC/SUM/VOL sequence.
   // NOTE: every variable gets a default first so no path infers a latch.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      snap_voices_d   = snap_voices_q;
      snap_route_d    = snap_route_q;
      snap_mode_d     = snap_mode_q;
      snap_last_off_d = snap_last_off_q;
      snap_vol_d      = snap_vol_q;
      pre_acc_d       = pre_acc_q;
      byp_acc_d       = byp_acc_q;
      pre_sat_d       = pre_sat_q;
      byp_sat_d       = byp_sat_q;
      clip_d          = clip_q;
      pre_o_d         = pre_o_q;
      byp_o_d         = byp_o_q;
      out_d           = out_q;
      valid_d         = 1'b0;
      overrun_d       = overrun_q | (bus.clkEn && (state_q != IDLE));

      case (state_q)
         IDLE: begin
            if (bus.clkEn) begin
               snap_voices_d   = bus.iVoices;
               snap_route_d    = route_q;
               snap_mode_d     = mode_q;
               snap_last_off_d = last_off_q;
               snap_vol_d      = vol_q;
               pre_acc_d       = '0;
               byp_acc_d       = '0;
               idx_d           = '0;
               state_d         = ACC;
            end
         end
         ACC: begin
            if (route_sel) begin
               pre_acc_d = pre_acc_q + voice_ext;
            end else if (!(idx_q == LAST_IDX && snap_last_off_q)) begin
               byp_acc_d = byp_acc_q + voice_ext;
            end
            if (idx_q == LAST_IDX) begin
               state_d = SUM;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         SUM: begin
            pre_sat_d = sat(WIDE_W'(pre_acc_q));
            byp_sat_d = byp_sat_now;
            clip_d    = sat(WIDE_W'(post));
            state_d   = VOL;
         end
         VOL: begin
            pre_o_d = pre_sat_q;
            byp_o_d = byp_sat_q;
            out_d   = SAMPLE_W'(vol_prod >>> 4);
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge iRstN) begin
      if (!iRstN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers; reset discards any mix in progress.
   // NOTE: the snapshot and accumulators are reset too, so no X can reach
   // the outputs even if the FSM is forced through an unusual sequence.
   always_ff @(posedge clk or negedge iRstN) begin
      if (!iRstN) begin
         idx_q           <= '0;
         snap_voices_q   <= '0;
         snap_route_q    <= '0;
         snap_mode_q     <= '0;
         snap_last_off_q <= 1'b0;
         snap_vol_q      <= '0;
         pre_acc_q       <= '0;
         byp_acc_q       <= '0;
         pre_sat_q       <= '0;
         byp_sat_q       <= '0;
         clip_q          <= '0;
         pre_o_q         <= '0;
         byp_o_q         <= '0;
         out_q           <= '0;
         valid_q         <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         idx_q           <= idx_d;
         snap_voices_q   <= snap_voices_d;
         snap_route_q    <= snap_route_d;
         snap_mode_q     <= snap_mode_d;
         snap_last_off_q <= snap_last_off_d;
         snap_vol_q      <= snap_vol_d;
         pre_acc_q       <= pre_acc_d;
         byp_acc_q       <= byp_acc_d;
         pre_sat_q       <= pre_sat_d;
         byp_sat_q       <= byp_sat_d;
         clip_q          <= clip_d;
         pre_o_q         <= pre_o_d;
         byp_o_q         <= byp_o_d;
         out_q           <= out_d;
         valid_q         <= valid_d;
         overrun_q       <= overrun_d;
      end
   end

   assign bus.oPreFilter = pre_o_q;
   assign bus.oBypass    = byp_o_q;
   assign bus.oOut       = out_q;
   assign bus.oValid     = valid_q;
   assign bus.oBusy      = (state_q != IDLE) || valid_q;
   assign bus.oOverrun   = overrun_q;

endmodule

// File: tb/tb_sid_voice_mixer.sv
// Directed self-checking bench for sid_voice_mixer (N=3, W=16, shift 3).
// Expected values are hand-computed for both builds of SID_MIXER_DC_EN.
module tb_sid_voice_mixer;

   logic clk;
   logic iRstN;
   int   tests;
   int   fails;

`ifdef SID_MIXER_DC_EN
   localparam bit DC_ON = 1'b1;
`else
   localparam bit DC_ON = 1'b0;
`endif

   sid_voice_mixer_if #(.NUM_VOICES(3), .SAMPLE_W(16)) bus ();

   sid_voice_mixer #(
      .NUM_VOICES(3),
      .SAMPLE_W(16),
      .HEADROOM_SHIFT(3),
      .BASE_ADDR('h17),
      .DC_OFFSET(-3746)
   ) dut (
      .clk  (clk),
      .iRstN(iRstN),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Choose the expectation for the current DC build.
   function automatic int pick(input int with_dc, input int without_dc);
      return DC_ON ? with_dc : without_dc;
   endfunction

   function automatic logic [47:0] pack3(input int v0, input int v1, input int v2);
      return {16'(v2), 16'(v1), 16'(v0)};
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] addr, input logic [7:0] data);
      bus.iWE    = 1'b1;
      bus.iAddr  = addr;
      bus.iDataW = data;
      tick();
      bus.iWE    = 1'b0;
   endtask

   // Wait, from cycle n, for oValid; returns the cycle it was seen in.
   task automatic wait_valid(input int start, output int n);
      n = start;
      while (!bus.oValid && n < 20) begin
         tick();
         n++;
      end
   endtask

   // Single mix: strobe, check busy, and check latency to oValid.
   task automatic run_mix(input string tag);
      int n;
      bus.clkEn = 1'b1;
      tick();
      bus.clkEn = 1'b0;
      check({tag, "_busy"}, bus.oBusy, 1);
      wait_valid(1, n);
      check({tag, "_latency"}, n, 6);
   endtask

   initial begin
      int n;
      int pulses;
      tests = 0;
      fails = 0;
      iRstN       = 1'b0;
      bus.clkEn   = 1'b0;
      bus.iWE     = 1'b0;
      bus.iAddr   = '0;
      bus.iDataW  = '0;
      bus.iVoices = '0;
      bus.iFiltLP = '0;
      bus.iFiltBP = '0;
      bus.iFiltHP = '0;

      // Step 1: reset held while clkEn pulses
      bus.clkEn = 1'b1;
      repeat (3) tick();
      bus.clkEn = 1'b0;
      check("rst_out", bus.oOut, 0);
      check("rst_valid", bus.oValid, 0);
      check("rst_busy", bus.oBusy, 0);
      check("rst_overrun", bus.oOverrun, 0);
      check("rst_pre", bus.oPreFilter, 0);
      check("rst_byp", bus.oBypass, 0);
      iRstN = 1'b1;
      tick();

      // Step 2: routing 0, mode 0, volume 15 from reset
      bus.iVoices = pack3(8000, -800, 160);
      run_mix("m1");
      check("m1_byp", bus.oBypass, 920);
      check("m1_pre", bus.oPreFilter, 0);
      check("m1_out", bus.oOut, pick(-2650, 862));
      tick();
      check("m1_valid_pulse", bus.oValid, 0);
      check("m1_busy_end", bus.oBusy, 0);
      check("m1_hold", bus.oBypass, 920);

      // Step 3: all voices to the filter input
      write_reg(5'h17, 8'h07);
      run_mix("m2");
      check("m2_pre", bus.oPreFilter, 920);
      check("m2_byp", bus.oBypass, 0);
      check("m2_out", bus.oOut, pick(-3512, 0));

      // Step 4: lastOff drops voice 2
      write_reg(5'h17, 8'h00);
      write_reg(5'h18, 8'h8F);
      run_mix("m3");
      check("m3_byp", bus.oBypass, 900);
      check("m3_pre", bus.oPreFilter, 0);
      check("m3_out", bus.oOut, pick(-2669, 843));

      // Step 5: positive saturation through LP
      write_reg(5'h18, 8'h1F);
      bus.iVoices = pack3(32767, 32767, 32767);
      bus.iFiltLP = 16'sd32767;
      run_mix("m4");
      check("m4_byp", bus.oBypass, 12285);
      check("m4_out", bus.oOut, 30719);

      // Step 6: negative saturation through LP
      bus.iVoices = pack3(-32768, -32768, -32768);
      bus.iFiltLP = -16'sd32768;
      run_mix("m5");
      check("m5_byp", bus.oBypass, -12288);
      check("m5_out", bus.oOut, -30720);

      // Step 7: BP+HP, volume 7, voice 1 routed, negative floor shift
      write_reg(5'h17, 8'h02);
      write_reg(5'h18, 8'h67);
      bus.iVoices = pack3(-8000, 4000, -1601);
      bus.iFiltLP = 16'sd10000;
      bus.iFiltBP = -16'sd2000;
      bus.iFiltHP = 16'sd300;
      run_mix("m6");
      check("m6_pre", bus.oPreFilter, 500);
      check("m6_byp", bus.oBypass, -1201);
      check("m6_out", bus.oOut, pick(-2909, -1270));

      // Step 8: clkEn together with a routing write takes the old routing
      bus.iWE    = 1'b1;
      bus.iAddr  = 5'h17;
      bus.iDataW = 8'h00;
      bus.clkEn  = 1'b1;
      tick();
      bus.iWE    = 1'b0;
      bus.clkEn  = 1'b0;
      wait_valid(1, n);
      check("m7_latency", n, 6);
      check("m7_pre", bus.oPreFilter, 500);

      // Step 9: new routing applies; a volume write mid-mix waits a mix
      bus.clkEn = 1'b1;
      tick();
      bus.clkEn = 1'b0;
      write_reg(5'h18, 8'h0F);
      wait_valid(2, n);
      check("m8_latency", n, 6);
      check("m8_pre", bus.oPreFilter, 0);
      check("m8_byp", bus.oBypass, -701);
      check("m8_out", bus.oOut, pick(-2690, -1051));

      // Step 10: clkEn two cycles into a mix is ignored and flags overrun
      bus.iVoices = pack3(8000, -800, 160);
      bus.iFiltLP = '0;
      bus.iFiltBP = '0;
      bus.iFiltHP = '0;
      check("ov_before", bus.oOverrun, 0);
      bus.clkEn = 1'b1;
      tick();
      bus.clkEn = 1'b0;
      tick();
      bus.clkEn = 1'b1;
      tick();
      bus.clkEn = 1'b0;
      wait_valid(3, n);
      check("ov_latency", n, 6);
      check("ov_byp", bus.oBypass, 920);
      check("ov_out", bus.oOut, pick(-2650, 862));
      check("ov_flag", bus.oOverrun, 1);
      pulses = 0;
      repeat (10) begin
         tick();
         if (bus.oValid) pulses++;
      end
      check("ov_no_second_mix", pulses, 0);
      check("ov_sticky", bus.oOverrun, 1);

      // Step 11: reset during ACC clears everything at once
      write_reg(5'h18, 8'h82);
      bus.clkEn = 1'b1;
      tick();
      bus.clkEn = 1'b0;
      tick();
      iRstN = 1'b0;
      #1;
      check("ar_out", bus.oOut, 0);
      check("ar_byp", bus.oBypass, 0);
      check("ar_pre", bus.oPreFilter, 0);
      check("ar_valid", bus.oValid, 0);
      check("ar_busy", bus.oBusy, 0);
      check("ar_overrun", bus.oOverrun, 0);
      tick();
      iRstN = 1'b1;
      pulses = 0;
      repeat (10) begin
         tick();
         if (bus.oValid) pulses++;
      end
      check("ar_no_valid", pulses, 0);

      // Step 12: registers are back at reset values (volume 15, no lastOff)
      run_mix("m9");
      check("m9_byp", bus.oBypass, 920);
      check("m9_out", bus.oOut, pick(-2650, 862));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
